// File: rtl/row_pair_feeder.sv
// Purpose : loads two 512-bit rows from a word stream, then presents a 3-bit window at each column of both rows.
// Latency : the window is valid the cycle after the last word is accepted; o_pair_done follows the last window by one cycle.
// Backpress: o_ready is low while scanning; the scan stalls indefinitely while i_win_ready is low.
// Build option: define ROW_PAIR_FEEDER_EDGE_PAD_EN to add two zero-padded windows at columns 510 and 511.
module row_pair_feeder #(
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [511:0]      o_1st_row_512bit,
    output logic [511:0]      o_2nd_row_512bit,
    output logic              o_win_valid,
    input  logic              i_win_ready,
    output logic [8:0]        o_col,
    output logic              o_pair_done
);

    localparam int NW     = 512 / WORD_W;
    localparam int NWORDS = 2 * NW;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

`ifdef ROW_PAIR_FEEDER_EDGE_PAD_EN
    // Scan runs past the window-fits boundary; the extra windows see zero fill.
    localparam logic [8:0] LASTC = 9'd511;
`else
    // Last column at which a 3-bit window still lies fully inside the row.
    localparam logic [8:0] LASTC = 9'd509;
`endif

    typedef enum logic {
        LOAD = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             r_state;
    logic [511:0]       r_row1;
    logic [511:0]       r_row2;
    logic [CNT_W-1:0]   r_wcnt;
    logic [8:0]         r_col;
    logic               r_pair_done;
    logic [1023:0]      w_load_chain;

    // Both rows behave as one 1024-bit shift chain while loading; new words enter at row 2's LSB end.
    assign w_load_chain = ({r_row1, r_row2} << WORD_W) | 1024'(i_data);

    assign o_ready          = (r_state == LOAD);
    assign o_win_valid      = (r_state == SCAN);
    assign o_1st_row_512bit = r_row1;
    assign o_2nd_row_512bit = r_row2;
    assign o_col            = r_col;
    assign o_pair_done      = r_pair_done;

    // Load/scan sequencer: flush beats any accept, last window returns to LOAD with a done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= LOAD;
            r_row1      <= '0;
            r_row2      <= '0;
            r_wcnt      <= '0;
            r_col       <= '0;
            r_pair_done <= 1'b0;
        end else begin
            r_pair_done <= 1'b0;
            if (i_flush) begin
                r_state <= LOAD;
                r_row1  <= '0;
                r_row2  <= '0;
                r_wcnt  <= '0;
                r_col   <= '0;
            end else begin
                case (r_state)
                    LOAD: begin
                        if (i_valid) begin
                            {r_row1, r_row2} <= w_load_chain;
                            if (r_wcnt == LAST_WORD) begin
                                r_wcnt  <= '0;
                                r_col   <= '0;
                                r_state <= SCAN;
                            end else begin
                                r_wcnt <= r_wcnt + 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (i_win_ready) begin
                            r_row1 <= {r_row1[510:0], 1'b0};
                            r_row2 <= {r_row2[510:0], 1'b0};
                            if (r_col == LASTC) begin
                                r_state     <= LOAD;
                                r_col       <= '0;
                                r_pair_done <= 1'b1;
                            end else begin
                                r_col <= r_col + 9'd1;
                            end
                        end
                    end
                    default: r_state <= LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_row_pair_feeder.sv
// Bench for row_pair_feeder: reference model of loaded rows and scan position, checked every cycle,
// plus hand-computed literal checks on the load order, window bits, flush and reset behaviour.
module tb_row_pair_feeder;

    localparam int WORD_W = 32;
    localparam int NW     = 16;
    localparam int NWORDS = 32;
`ifdef ROW_PAIR_FEEDER_EDGE_PAD_EN
    localparam int LASTC = 511;
`else
    localparam int LASTC = 509;
`endif
    localparam int NWIN = LASTC + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic [WORD_W-1:0]  data = '0;
    logic               valid = 1'b0;
    logic               win_ready = 1'b0;
    logic               o_ready;
    logic [511:0]       o_r1;
    logic [511:0]       o_r2;
    logic               o_win_valid;
    logic [8:0]         o_col;
    logic               o_pair_done;

    int errors = 0;
    int checks = 0;

    logic [WORD_W-1:0] words [NWORDS];

    row_pair_feeder #(.WORD_W(WORD_W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_data           (data),
        .i_valid          (valid),
        .o_ready          (o_ready),
        .o_1st_row_512bit (o_r1),
        .o_2nd_row_512bit (o_r2),
        .o_win_valid      (o_win_valid),
        .i_win_ready      (win_ready),
        .o_col            (o_col),
        .o_pair_done      (o_pair_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit                 m_load;
    logic [WORD_W-1:0]  m_q[$];
    logic [1023:0]      m_base;
    logic [511:0]       m_r1;
    logic [511:0]       m_r2;
    int                 m_col;
    bit                 m_pd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            m_load = 1'b1;
            m_q.delete();
            m_base = '0;
            m_r1   = '0;
            m_r2   = '0;
            m_col  = 0;
            m_pd   = 1'b0;
        end else if (m_load) begin
            m_pd = 1'b0;
            if (valid) begin
                m_q.push_back(data);
                if (m_q.size() == NWORDS) begin
                    for (int i = 0; i < NW; i++) begin
                        m_r1[511-WORD_W*i -: WORD_W] = m_q[i];
                        m_r2[511-WORD_W*i -: WORD_W] = m_q[NW+i];
                    end
                    m_q.delete();
                    m_load = 1'b0;
                    m_col  = 0;
                end
            end
        end else begin
            m_pd = 1'b0;
            if (win_ready) begin
                if (m_col == LASTC) begin
                    m_base = {m_r1 << (LASTC + 1), m_r2 << (LASTC + 1)};
                    m_load = 1'b1;
                    m_col  = 0;
                    m_pd   = 1'b1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [1023:0] ch;
        logic [511:0]  e1;
        logic [511:0]  e2;
        if (m_load) begin
            ch = m_base << (WORD_W * m_q.size());
            foreach (m_q[i]) ch = ch | (1024'(m_q[i]) << (WORD_W * (m_q.size() - 1 - i)));
            e1 = ch[1023:512];
            e2 = ch[511:0];
        end else begin
            e1 = m_r1 << m_col;
            e2 = m_r2 << m_col;
        end
        chk("m_ready",     512'(o_ready),     512'(m_load));
        chk("m_win_valid", 512'(o_win_valid), 512'(!m_load));
        chk("m_col",       512'(o_col),       512'(m_col));
        chk("m_pair_done", 512'(o_pair_done), 512'(m_pd));
        chk("m_row1",      o_r1,              e1);
        chk("m_row2",      o_r2,              e2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_pair(input bit gaps);
        for (int i = 0; i < NWORDS; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                data  = $urandom;
                @(posedge clk); #1;
            end
            valid = 1'b1;
            data  = words[i];
            @(posedge clk); #1;
        end
        valid = 1'b0;
    endtask

    // mode 0: toggle ready, 1: ready high, 2: random ready, 3: random ready with junk valid words
    task automatic scan_pair(input int mode, output int acc, output int pulses, output bit seq_ok);
        int start;
        start  = int'(o_col);
        acc    = 0;
        pulses = 0;
        seq_ok = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            case (mode)
                0:       win_ready = (c % 2 == 0);
                1:       win_ready = 1'b1;
                default: win_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (mode == 3) begin
                valid = 1'b1;
                data  = $urandom;
            end
            if (win_ready && o_win_valid) begin
                if (int'(o_col) != start + acc) seq_ok = 1'b0;
                acc++;
            end
            @(posedge clk); #1;
            if (o_pair_done) pulses++;
            if (o_ready && acc > 0) break;
        end
        win_ready = 1'b0;
        valid     = 1'b0;
    endtask

    task automatic random_words();
        foreach (words[i]) words[i] = $urandom;
    endtask

    int acc;
    int pulses;
    bit seq_ok;

    initial begin
        // Reset state is covered by the model compare while rst_n is low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 512'(o_ready), 512'(1));
        chk("rst_rows",  o_r1 | o_r2,   '0);
        rst_n = 1'b1;

        // Sequential words 1..32, back to back.
        foreach (words[i]) words[i] = WORD_W'(i + 1);
        load_pair(1'b0);
        chk("seq_ready_low", 512'(o_ready),       512'(0));
        chk("seq_win_valid", 512'(o_win_valid),   512'(1));
        chk("seq_col0",      512'(o_col),         512'(0));
        chk("seq_row1_msw",  512'(o_r1[511:480]), 512'(32'h0000_0001));
        chk("seq_row2_lsw",  512'(o_r2[31:0]),    512'(32'h0000_0020));

        // Toggled ready: every column exactly once, one done pulse.
        scan_pair(0, acc, pulses, seq_ok);
        chk("tog_accepts", 512'(acc),     512'(NWIN));
        chk("tog_pulses",  512'(pulses),  512'(1));
        chk("tog_seq",     512'(seq_ok),  512'(1));
        chk("tog_ready",   512'(o_ready), 512'(1));
        @(posedge clk); #1;
        chk("tog_pulse_len", 512'(o_pair_done), 512'(0));

        // Window bit patterns.
        foreach (words[i]) words[i] = '0;
        words[0]  = 32'hA000_0000;
        words[NW] = 32'hE000_0000;
        load_pair(1'b0);
        chk("win_c0_r1", 512'(o_r1[511:509]), 512'(3'b101));
        chk("win_c0_r2", 512'(o_r2[511:509]), 512'(3'b111));
        win_ready = 1'b1;
        @(posedge clk); #1;
        chk("win_c1_r1", 512'(o_r1[511:509]), 512'(3'b010));
        chk("win_c1_r2", 512'(o_r2[511:509]), 512'(3'b110));
        scan_pair(1, acc, pulses, seq_ok);
        chk("win_rest_acc", 512'(acc), 512'(NWIN - 1));

        // Flush mid-scan at column 100.
        random_words();
        load_pair(1'b1);
        win_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (o_col == 9'd100) break;
            @(posedge clk); #1;
        end
        chk("fl_at100", 512'(o_col), 512'(100));
        flush = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        win_ready = 1'b0;
        chk("fl_ready", 512'(o_ready),     512'(1));
        chk("fl_col",   512'(o_col),       512'(0));
        chk("fl_rows",  o_r1 | o_r2,       '0);
        chk("fl_pd",    512'(o_pair_done), 512'(0));
        @(posedge clk); #1;
        chk("fl_pd2",   512'(o_pair_done), 512'(0));
        random_words();
        load_pair(1'b0);
        scan_pair(1, acc, pulses, seq_ok);
        chk("fl_next_acc", 512'(acc),    512'(NWIN));
        chk("fl_next_pd",  512'(pulses), 512'(1));

        // Reset after 20 words: a full reload is required.
        random_words();
        valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data = words[i];
            @(posedge clk); #1;
        end
        valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rr_ready", 512'(o_ready),     512'(1));
        chk("rr_wv",    512'(o_win_valid), 512'(0));
        rst_n = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < NWORDS - 1; i++) begin
            data = words[i];
            @(posedge clk); #1;
        end
        chk("rr_wv_31", 512'(o_win_valid), 512'(0));
        data = words[NWORDS-1];
        @(posedge clk); #1;
        valid = 1'b0;
        chk("rr_wv_32", 512'(o_win_valid), 512'(1));
        chk("rr_row1",  512'(o_r1[511:480]), 512'(words[0]));

        // i_valid held during scan must not disturb the rows.
        scan_pair(3, acc, pulses, seq_ok);
        chk("sv_acc", 512'(acc),    512'(NWIN));
        chk("sv_seq", 512'(seq_ok), 512'(1));

        // Random pairs with load gaps and random backpressure.
        for (int p = 0; p < 2; p++) begin
            random_words();
            load_pair(1'b1);
            scan_pair(2, acc, pulses, seq_ok);
            chk("rnd_acc",    512'(acc),    512'(NWIN));
            chk("rnd_pulses", 512'(pulses), 512'(1));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
